host_bridge_hb: RTL and testbench
=================================

Name: host_bridge_hb

Overview:
- hb_clk-side controller for the SPI host bridge buffer.
- Generalises the single-strobe write path to NSRC independent data sources, each with a one-deep capture latch.
- Selects between fixed-priority and round-robin arbitration; detects buffer overflow and source drops; owns the boot HALT/LOAD/RUN sequencer and the host SRQ handshake.
- Drives port B of the external dual-port bridge BRAM; the ha_clk side (SPI shifter, ha_ack) is unchanged.

Parameters:
- NSRC, 5: number of streaming sources (gps, mem, rx, wf, ext order by convention).
- DW, 16: data width of sources, tos and buffer port B.
- DEPTH, 2048: port-B depth in words; power of two, at least 4.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- hb_clk  in  1  system clock.
- ha_rst  in  1  reset, asynchronous, active-high.
- src_req  in  NSRC  one-cycle write request per source.
- src_data  in  NSRC*DW  source data; slice i is valid in the src_req[i] cycle.
- host_wr  in  1  direct write of tos (HOST_TX).
- tos  in  DW  top of stack.
- host_rd  in  1  buffer read (HOST_RX).
- host_rst  in  1  pointer/flag reset event.
- host_rdy  in  1  CPU ready event.
- host_poll  in  1  synchronized host-CS fall.
- hb_ack  in  1  synchronized ha_ack.
- boot_halt  in  1  synchronized boot-CS rise.
- boot_load  in  1  synchronized boot-CS fall.
- buf_addr  out  clog2(DEPTH)  port-B address.
- buf_we  out  1  port-B write enable.
- buf_din  out  DW  port-B write data.
- buf_dout  in  DW  port-B read data.
- host_dout  out  DW  read data; zero when not reading.
- host_srq  out  1  service request pulse.
- hb_rdy  out  1  ready flag to ha-side sync.
- run_st  out  2  {RUN, LOAD} state.
- boot_done  out  1  load-complete pulse.
- buf_ovfl  out  1  sticky: write dropped because the buffer is full.
- src_lost  out  NSRC  sticky per source: request dropped because that source was still pending.

Behaviour:
- Reset values: run_st=00 (HALT); hb_rdy=0; buf_ovfl=0; src_lost=0; all pending latches empty; pos=0; full=0; round-robin pointer=NSRC-1. Combinational outputs follow these values.
- Boot sequencer, priority order: boot_halt sets 00, then boot_load sets 01, then boot_done sets 10.
- boot_rst = (run_st==00); boot_rd = run_st[0]; rd = host_rd|boot_rd; brst = host_rst|boot_rst.
- Address, combinational: {carry, buf_addr} = brst ? 0 : pos + rd.
- boot_done = carry & run_st[0]. It fires exactly once, when the read pointer wraps from DEPTH-1 to 0 during LOAD.
- Pointer update: pos <= buf_addr + buf_we, registered and wrapping modulo DEPTH.
- Capture: on src_req[i], if pending[i]=0, latch src_data slice i and set pending[i].
  - If pending[i]=1 and it is not granted this cycle, drop the new request and set src_lost[i].
  - If pending[i]=1 and it is granted this cycle, accept the new data (back-to-back at full rate).
- Grant: at most one buffer write per cycle.
  - host_wr has top priority: buf_din=tos and all pending sources wait.
  - Otherwise one pending source is granted: ARB_MODE 0 picks the lowest index; ARB_MODE 1 picks the first pending index after the last granted one, wrapping.
  - The granted latch clears the same cycle unless it is re-captured.
- Latency: a source request reaches buf_we at best 1 cycle later.
- Overflow:
  - A write issued while buf_addr==DEPTH-1 sets full.
  - While full=1: buf_we=0, the pending latch is still consumed, and buf_ovfl is set.
  - brst clears full and pos. buf_ovfl and src_lost clear only on host_rst.
- Read and write in the same cycle are allowed: read uses buf_addr, write uses the same buf_addr, and pos advances by rd+we.
- host_dout = rd ? buf_dout : 0. The zero is mandatory because stack side-effects depend on it.
- SRQ handshake:
  - host_srq = host_poll & hb_ack (combinational).
  - hb_rdy is set by host_rdy and cleared by host_srq; clear wins when both occur.
- Reset mid-operation clears latches immediately; no partial write is issued after ha_rst deasserts.

Decomposition:
- Package host_bridge_pkg holds:
  - run_st encodings: HALT=00, LOAD=01, RUN=10.
  - ARB_FIXED=0, ARB_RR=1.
  - clog2 function.
  - RISE/FALL edge constants.
- Sub-module host_src_arb (NSRC, DW, ARB_MODE) holds the pending latches, src_lost, the arbiter and the data mux. Outputs are grant_valid and grant_data; input is the block signal from host_wr.

Test Plan:
- Reset, boot_halt, then boot_load, then 2048 cycles with DEPTH=2048: buf_addr steps 0..2047; boot_done pulses once on the wrap cycle; run_st goes 00→01→10; host_dout=0 afterwards.
- ARB_MODE=0, src_req=5'b10101 in one cycle with data A,B,C: writes occur at addresses 0,1,2 in source order 0,2,4 over 3 consecutive cycles; src_lost=0.
- ARB_MODE=1, sources 1 and 3 requesting every cycle for 6 cycles: grants alternate 1,3,1,3; source 3 sets src_lost[3] once its latch is still pending when re-requested.
- host_wr asserted with src_req[0] in the same cycle, tos=16'h1234: buf_din=1234 at addr 0; source 0 data lands at addr 1 the next cycle.
- DEPTH=4, issue 6 writes: addresses 0..3 are written; the 5th and 6th give buf_we=0 and buf_ovfl=1; host_rst clears buf_ovfl and returns pos to 0.
- host_rdy, then host_poll with hb_ack=1: host_srq pulses 1 cycle and hb_rdy clears; host_poll with hb_ack=0 gives no srq and hb_rdy holds.

Source files
------------

// File: rtl/host_bridge_pkg.sv
// Shared encodings and helpers for the hb_clk side of the SPI host bridge.
package host_bridge_pkg;

  localparam logic [1:0] ST_HALT = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/host_src_arb.sv
// Per-source one-deep capture latches, drop tracking and the write arbiter.
module host_src_arb
  import host_bridge_pkg::*;
#(
  parameter int NSRC     = 5,
  parameter int DW       = 16,
  parameter int ARB_MODE = 0
) (
  input  logic               hb_clk,
  input  logic               ha_rst,
  input  logic               clr_lost,
  input  logic               block,
  input  logic [NSRC-1:0]    src_req,
  input  logic [NSRC*DW-1:0] src_data,
  output logic               grant_valid,
  output logic [DW-1:0]      grant_data,
  output logic [NSRC-1:0]    src_lost
);

  localparam int IW = (NSRC > 1) ? clog2(NSRC) : 1;

  logic [NSRC-1:0]    pend_q, pend_d, lost_q, lost_d, gnt_oh_s;
  logic [NSRC*DW-1:0] data_q, data_d;
  logic [IW-1:0]      last_q, last_d, gnt_idx_s;

  // Pick a winner; loops run so the last hit is the highest-priority one.
  always_comb begin
    gnt_idx_s = {IW{1'b0}};
    if (ARB_MODE == ARB_RR) begin
      for (int k = NSRC; k >= 1; k--) begin
        gnt_idx_s = pend_q[(int'(last_q) + k) % NSRC] ? IW'((int'(last_q) + k) % NSRC) : gnt_idx_s;
      end
    end else begin
      for (int k = NSRC - 1; k >= 0; k--) begin
        gnt_idx_s = pend_q[k] ? IW'(k) : gnt_idx_s;
      end
    end
  end

  assign grant_valid = (|pend_q) & ~block;
  assign grant_data  = data_q[gnt_idx_s*DW +: DW];
  assign src_lost    = lost_q;

  always_comb begin
    for (int i = 0; i < NSRC; i++) gnt_oh_s[i] = grant_valid && (gnt_idx_s == IW'(i));
  end

  // A granted latch may be refilled in the same cycle, so a source can stream at full rate.
  always_comb begin
    pend_d = pend_q;
    data_d = data_q;
    lost_d = clr_lost ? {NSRC{1'b0}} : lost_q;
    last_d = grant_valid ? gnt_idx_s : last_q;
    for (int i = 0; i < NSRC; i++) begin
      if (src_req[i] && (!pend_q[i] || gnt_oh_s[i])) begin
        pend_d[i]            = 1'b1;
        data_d[i*DW +: DW]   = src_data[i*DW +: DW];
      end else if (src_req[i]) begin
        lost_d[i]            = 1'b1;
      end else if (gnt_oh_s[i]) begin
        pend_d[i]            = 1'b0;
      end else begin
        pend_d[i]            = pend_q[i];
      end
    end
  end

  // Latch and pointer state.
  always_ff @(posedge hb_clk or posedge ha_rst) begin
    if (ha_rst) begin
      pend_q <= {NSRC{1'b0}};
      lost_q <= {NSRC{1'b0}};
      data_q <= {(NSRC*DW){1'b0}};
      last_q <= IW'(NSRC - 1);
    end else begin
      pend_q <= pend_d;
      lost_q <= lost_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/host_bridge_hb.sv
// hb_clk-side controller: boot sequencer, port-B pointer/overflow logic, SRQ handshake.
module host_bridge_hb
  import host_bridge_pkg::*;
#(
  parameter int NSRC     = 5,
  parameter int DW       = 16,
  parameter int DEPTH    = 2048,
  parameter int ARB_MODE = 0
) (
  input  logic                      hb_clk,
  input  logic                      ha_rst,
  input  logic [NSRC-1:0]           src_req,
  input  logic [NSRC*DW-1:0]        src_data,
  input  logic                      host_wr,
  input  logic [DW-1:0]             tos,
  input  logic                      host_rd,
  input  logic                      host_rst,
  input  logic                      host_rdy,
  input  logic                      host_poll,
  input  logic                      hb_ack,
  input  logic                      boot_halt,
  input  logic                      boot_load,
  output logic [clog2(DEPTH)-1:0]   buf_addr,
  output logic                      buf_we,
  output logic [DW-1:0]             buf_din,
  input  logic [DW-1:0]             buf_dout,
  output logic [DW-1:0]             host_dout,
  output logic                      host_srq,
  output logic                      hb_rdy,
  output logic [1:0]                run_st,
  output logic                      boot_done,
  output logic                      buf_ovfl,
  output logic [NSRC-1:0]           src_lost
);

  localparam int AW = clog2(DEPTH);

  logic [1:0]    run_st_q, run_st_d;
  logic [AW-1:0] pos_q, pos_d, addr_s;
  logic          full_q, full_d, ovfl_q, ovfl_d, rdy_q, rdy_d;
  logic          grant_valid_s, rd_s, brst_s, carry_s, issue_s, we_s;
  logic [DW-1:0] grant_data_s;
  logic [AW:0]   sum_s;

  host_src_arb #(.NSRC(NSRC), .DW(DW), .ARB_MODE(ARB_MODE)) u_arb (
    .hb_clk     (hb_clk),
    .ha_rst     (ha_rst),
    .clr_lost   (host_rst),
    .block      (host_wr),
    .src_req    (src_req),
    .src_data   (src_data),
    .grant_valid(grant_valid_s),
    .grant_data (grant_data_s),
    .src_lost   (src_lost)
  );

  // LOAD streams the buffer out through the read path; HALT holds the pointer at zero.
  assign rd_s    = host_rd | run_st_q[0];
  assign brst_s  = host_rst | (run_st_q == ST_HALT);
  assign sum_s   = {1'b0, pos_q} + {{AW{1'b0}}, rd_s};
  assign issue_s = host_wr | grant_valid_s;
  assign we_s    = issue_s & ~full_q;

  // Pointer pre-increments on read; carry out marks the end of a full LOAD pass.
  always_comb begin
    if (brst_s) begin
      {carry_s, addr_s} = {(AW+1){1'b0}};
    end else begin
      {carry_s, addr_s} = sum_s;
    end
  end

  assign buf_addr  = addr_s;
  assign buf_we    = we_s;
  assign buf_din   = host_wr ? tos : grant_data_s;
  assign host_dout = rd_s ? buf_dout : {DW{1'b0}};
  assign boot_done = carry_s & run_st_q[0];
  assign host_srq  = host_poll & hb_ack;
  assign hb_rdy    = rdy_q;
  assign run_st    = run_st_q;
  assign buf_ovfl  = ovfl_q;

  // Next-state for sequencer, pointer, full/overflow and ready flags.
  always_comb begin
    pos_d = addr_s + {{(AW-1){1'b0}}, we_s};
    if (boot_halt)      run_st_d = ST_HALT;
    else if (boot_load) run_st_d = ST_LOAD;
    else if (boot_done) run_st_d = ST_RUN;
    else                run_st_d = run_st_q;
    if (brst_s)                                    full_d = 1'b0;
    else if (we_s && (addr_s == AW'(DEPTH - 1)))   full_d = 1'b1;
    else                                           full_d = full_q;
    if (host_rst)                ovfl_d = 1'b0;
    else if (issue_s && full_q)  ovfl_d = 1'b1;
    else                         ovfl_d = ovfl_q;
    if (host_srq)      rdy_d = 1'b0;
    else if (host_rdy) rdy_d = 1'b1;
    else               rdy_d = rdy_q;
  end

  // State registers.
  always_ff @(posedge hb_clk or posedge ha_rst) begin
    if (ha_rst) begin
      run_st_q <= ST_HALT;
      pos_q    <= {AW{1'b0}};
      full_q   <= 1'b0;
      ovfl_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      run_st_q <= run_st_d;
      pos_q    <= pos_d;
      full_q   <= full_d;
      ovfl_q   <= ovfl_d;
      rdy_q    <= rdy_d;
    end
  end

endmodule

// File: tb/tb_host_bridge_hb.sv
// Directed bench: three bridge instances (2048/fixed, 16/round-robin, 4/fixed) share stimulus.
module tb_host_bridge_hb;

  localparam int NSRC = 5;
  localparam int DW   = 16;

  logic              hb_clk = 1'b0;
  logic              ha_rst;
  logic [NSRC-1:0]   src_req;
  logic [NSRC*DW-1:0] src_data;
  logic              host_wr, host_rd, host_rst, host_rdy, host_poll, hb_ack;
  logic              boot_halt, boot_load;
  logic [DW-1:0]     tos, buf_dout;

  logic [10:0] a_addr;  logic a_we, a_srq, a_rdy, a_done, a_ovfl;
  logic [3:0]  b_addr;  logic b_we, b_srq, b_rdy, b_done, b_ovfl;
  logic [1:0]  c_addr;  logic c_we, c_srq, c_rdy, c_done, c_ovfl;
  logic [DW-1:0] a_din, a_dout, b_din, b_dout, c_din, c_dout;
  logic [1:0]    a_run, b_run, c_run;
  logic [NSRC-1:0] a_lost, b_lost, c_lost;

  int n_checks = 0;
  int n_errors = 0;

  always #5 hb_clk = ~hb_clk;

  host_bridge_hb #(.NSRC(NSRC), .DW(DW), .DEPTH(2048), .ARB_MODE(0)) u_a (
    .hb_clk(hb_clk), .ha_rst(ha_rst), .src_req(src_req), .src_data(src_data),
    .host_wr(host_wr), .tos(tos), .host_rd(host_rd), .host_rst(host_rst),
    .host_rdy(host_rdy), .host_poll(host_poll), .hb_ack(hb_ack),
    .boot_halt(boot_halt), .boot_load(boot_load), .buf_addr(a_addr), .buf_we(a_we),
    .buf_din(a_din), .buf_dout(buf_dout), .host_dout(a_dout), .host_srq(a_srq),
    .hb_rdy(a_rdy), .run_st(a_run), .boot_done(a_done), .buf_ovfl(a_ovfl), .src_lost(a_lost));

  host_bridge_hb #(.NSRC(NSRC), .DW(DW), .DEPTH(16), .ARB_MODE(1)) u_b (
    .hb_clk(hb_clk), .ha_rst(ha_rst), .src_req(src_req), .src_data(src_data),
    .host_wr(host_wr), .tos(tos), .host_rd(host_rd), .host_rst(host_rst),
    .host_rdy(host_rdy), .host_poll(host_poll), .hb_ack(hb_ack),
    .boot_halt(boot_halt), .boot_load(boot_load), .buf_addr(b_addr), .buf_we(b_we),
    .buf_din(b_din), .buf_dout(buf_dout), .host_dout(b_dout), .host_srq(b_srq),
    .hb_rdy(b_rdy), .run_st(b_run), .boot_done(b_done), .buf_ovfl(b_ovfl), .src_lost(b_lost));

  host_bridge_hb #(.NSRC(NSRC), .DW(DW), .DEPTH(4), .ARB_MODE(0)) u_c (
    .hb_clk(hb_clk), .ha_rst(ha_rst), .src_req(src_req), .src_data(src_data),
    .host_wr(host_wr), .tos(tos), .host_rd(host_rd), .host_rst(host_rst),
    .host_rdy(host_rdy), .host_poll(host_poll), .hb_ack(hb_ack),
    .boot_halt(boot_halt), .boot_load(boot_load), .buf_addr(c_addr), .buf_we(c_we),
    .buf_din(c_din), .buf_dout(buf_dout), .host_dout(c_dout), .host_srq(c_srq),
    .hb_rdy(c_rdy), .run_st(c_run), .boot_done(c_done), .buf_ovfl(c_ovfl), .src_lost(c_lost));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Each cycle starts at the falling edge with all pulse inputs idle.
  task automatic next_cyc();
    @(negedge hb_clk);
    src_req   = '0;
    src_data  = '0;
    host_wr   = 1'b0;
    host_rd   = 1'b0;
    host_rst  = 1'b0;
    host_rdy  = 1'b0;
    host_poll = 1'b0;
    hb_ack    = 1'b0;
    boot_halt = 1'b0;
    boot_load = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [DW-1:0] d);
    src_req[i]          = 1'b1;
    src_data[i*DW +: DW] = d;
  endtask

  logic [DW-1:0] arb0_exp [3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
  logic          rr_we    [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [DW-1:0] rr_din   [9] = '{16'h0000, 16'h1000, 16'h3000, 16'h1001, 16'h3002,
                                  16'h1003, 16'h3004, 16'h1005, 16'h0000};

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    ha_rst = 1'b1; tos = 16'h0000; buf_dout = 16'hBEEF;
    src_req = '0; src_data = '0; host_wr = 1'b0; host_rd = 1'b0; host_rst = 1'b0;
    host_rdy = 1'b0; host_poll = 1'b0; hb_ack = 1'b0; boot_halt = 1'b0; boot_load = 1'b0;
    repeat (2) @(negedge hb_clk);
    #1;
    check_val("rst_run", 32'(a_run), 32'h0);
    check_val("rst_rdy", 32'(a_rdy), 32'h0);
    check_val("rst_ovfl", 32'(a_ovfl), 32'h0);
    check_val("rst_lost", 32'(a_lost), 32'h0);
    check_val("rst_we", 32'(a_we), 32'h0);
    check_val("rst_addr", 32'(a_addr), 32'h0);
    check_val("rst_dout", 32'(a_dout), 32'h0);

    next_cyc(); ha_rst = 1'b0;
    next_cyc(); boot_halt = 1'b1; #1;
    check_val("halt_run", 32'(a_run), 32'h0);
    next_cyc(); boot_load = 1'b1; #1;
    check_val("load_req_addr", 32'(a_addr), 32'h0);
    for (int k = 0; k < 2048; k++) begin
      next_cyc(); #1;
      check_val("boot_addr", 32'(a_addr), 32'((k + 1) % 2048));
      check_val("boot_done", 32'(a_done), 32'(k == 2047));
      check_val("boot_run", 32'(a_run), 32'h1);
      check_val("boot_dout", 32'(a_dout), 32'hBEEF);
    end
    next_cyc(); #1;
    check_val("run_a", 32'(a_run), 32'h2);
    check_val("run_b", 32'(b_run), 32'h2);
    check_val("run_c", 32'(c_run), 32'h2);
    check_val("run_dout", 32'(a_dout), 32'h0);
    check_val("run_done", 32'(a_done), 32'h0);
    check_val("run_addr", 32'(a_addr), 32'h0);
    next_cyc(); host_rd = 1'b1; #1;
    check_val("hrd_dout", 32'(a_dout), 32'hBEEF);
    check_val("hrd_addr", 32'(a_addr), 32'h1);
    next_cyc(); host_rst = 1'b1; #1;
    check_val("hrst_addr", 32'(a_addr), 32'h0);

    // Fixed priority: three sources in one cycle drain in index order.
    next_cyc(); set_src(0, 16'hAAAA); set_src(2, 16'hBBBB); set_src(4, 16'hCCCC); #1;
    check_val("arb0_we_cap", 32'(a_we), 32'h0);
    for (int j = 0; j < 3; j++) begin
      next_cyc(); #1;
      check_val("arb0_we", 32'(a_we), 32'h1);
      check_val("arb0_addr", 32'(a_addr), 32'(j));
      check_val("arb0_din", 32'(a_din), 32'(arb0_exp[j]));
    end
    next_cyc(); #1;
    check_val("arb0_idle", 32'(a_we), 32'h0);
    check_val("arb0_lost", 32'(a_lost), 32'h0);
    next_cyc(); host_rst = 1'b1;

    // Round-robin: sources 1 and 3 hammering every cycle alternate and drop.
    for (int c = 0; c < 9; c++) begin
      next_cyc();
      if (c < 6) begin
        set_src(1, 16'h1000 + 16'(c));
        set_src(3, 16'h3000 + 16'(c));
      end
      #1;
      check_val("rr_we", 32'(b_we), 32'(rr_we[c]));
      check_val("rr_addr", 32'(b_addr), 32'((c == 0) ? 0 : c - 1));
      if (rr_we[c]) check_val("rr_din", 32'(b_din), 32'(rr_din[c]));
      if (c == 2) check_val("rr_lost3", 32'(b_lost), 32'h08);
    end
    check_val("rr_lost_end", 32'(b_lost), 32'h0A);
    repeat (2) next_cyc();
    next_cyc(); host_rst = 1'b1;

    // host_wr pre-empts a source captured in the same cycle.
    next_cyc(); host_wr = 1'b1; tos = 16'h1234; set_src(0, 16'h5555); #1;
    check_val("hwr_we", 32'(a_we), 32'h1);
    check_val("hwr_addr", 32'(a_addr), 32'h0);
    check_val("hwr_din", 32'(a_din), 32'h1234);
    next_cyc(); #1;
    check_val("hwr_src_we", 32'(a_we), 32'h1);
    check_val("hwr_src_addr", 32'(a_addr), 32'h1);
    check_val("hwr_src_din", 32'(a_din), 32'h5555);
    next_cyc(); #1;
    check_val("hwr_idle", 32'(a_we), 32'h0);
    next_cyc(); host_rst = 1'b1;

    // Overflow on the 4-deep instance.
    for (int c = 0; c < 6; c++) begin
      next_cyc(); host_wr = 1'b1; tos = 16'(c);
      if (c == 5) set_src(0, 16'h7777);
      #1;
      check_val("ovf_we", 32'(c_we), 32'(c < 4));
      check_val("ovf_addr", 32'(c_addr), 32'((c < 4) ? c : 0));
      if (c == 5) check_val("ovf_flag", 32'(c_ovfl), 32'h1);
    end
    next_cyc(); #1;
    check_val("ovf_src_we", 32'(c_we), 32'h0);
    check_val("ovf_flag_hold", 32'(c_ovfl), 32'h1);
    next_cyc(); host_rst = 1'b1;
    next_cyc(); #1;
    check_val("ovf_clr", 32'(c_ovfl), 32'h0);
    check_val("ovf_consumed", 32'(c_we), 32'h0);
    check_val("ovf_pos", 32'(c_addr), 32'h0);
    next_cyc(); host_wr = 1'b1; tos = 16'h00AA; #1;
    check_val("ovf_rewr_we", 32'(c_we), 32'h1);
    check_val("ovf_rewr_addr", 32'(c_addr), 32'h0);
    check_val("ovf_rewr_din", 32'(c_din), 32'h00AA);
    next_cyc(); host_rst = 1'b1;

    // SRQ handshake.
    next_cyc(); host_rdy = 1'b1; #1;
    check_val("srq_rdy0", 32'(a_rdy), 32'h0);
    next_cyc(); host_poll = 1'b1; hb_ack = 1'b0; #1;
    check_val("srq_noack", 32'(a_srq), 32'h0);
    check_val("srq_rdy1", 32'(a_rdy), 32'h1);
    next_cyc(); host_poll = 1'b1; hb_ack = 1'b1; #1;
    check_val("srq_pulse", 32'(a_srq), 32'h1);
    check_val("srq_rdy_hold", 32'(a_rdy), 32'h1);
    next_cyc(); #1;
    check_val("srq_end", 32'(a_srq), 32'h0);
    check_val("srq_rdy_clr", 32'(a_rdy), 32'h0);
    next_cyc(); host_rdy = 1'b1; host_poll = 1'b1; hb_ack = 1'b1; #1;
    check_val("srq_both", 32'(a_srq), 32'h1);
    next_cyc(); #1;
    check_val("srq_clr_wins", 32'(a_rdy), 32'h0);

    // Reset with every latch full: nothing may be written afterwards.
    next_cyc();
    for (int i = 0; i < NSRC; i++) set_src(i, 16'h9000 + 16'(i));
    next_cyc(); ha_rst = 1'b1; #1;
    check_val("mrst_we", 32'(a_we), 32'h0);
    check_val("mrst_run", 32'(a_run), 32'h0);
    next_cyc(); ha_rst = 1'b0; #1;
    check_val("mrst_we_rel", 32'(a_we), 32'h0);
    check_val("mrst_we_rel_b", 32'(b_we), 32'h0);
    next_cyc(); #1;
    check_val("mrst_we_post", 32'(a_we), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
